// File: rtl/otter_fb_arbiter.sv
// otter_fb_arbiter: single-port framebuffer RAM arbiter between the OTTER
// MEM stage and the VGA scan-out fetcher. VGA normally wins; a saturating
// wait counter forces a CPU grant after MAX_CPU_WAIT lost cycles. Read data
// from the synchronous RAM is steered back to whichever side issued the read.
module otter_fb_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int MAX_CPU_WAIT = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CPU_RD,
  input  logic              CPU_WR,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_WDATA,
  output logic [DATA_W-1:0] CPU_RDATA,
  output logic              CPU_RVALID,
  output logic              CPU_STALL,
  input  logic              VGA_REQ,
  input  logic [ADDR_W-1:0] VGA_ADDR,
  output logic              VGA_GNT,
  output logic [DATA_W-1:0] VGA_RDATA,
  output logic              VGA_RVALID,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  localparam int WAIT_W = $clog2(MAX_CPU_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_CPU_WAIT);

  typedef enum logic {
    C_IDLE,
    C_RDWAIT
  } cpu_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_VGA
  } owner_t;

  cpu_state_t        cpu_state;
  owner_t            owner;
  logic [WAIT_W-1:0] cpu_wait;

  logic cpu_req;
  logic cpu_write;
  logic cpu_eligible;
  logic cpu_pending;
  logic cpu_gnt;
  logic vga_gnt;

  // Decide who owns the RAM this cycle; nothing is granted while in reset.
  always_comb begin
    cpu_req      = CPU_RD | CPU_WR;
    cpu_write    = CPU_WR;
    cpu_pending  = RST_N && (cpu_state == C_IDLE) && cpu_req;
    cpu_eligible = cpu_pending;
    cpu_gnt      = cpu_eligible && (!VGA_REQ || (cpu_wait == WAIT_LIMIT));
    vga_gnt      = RST_N && VGA_REQ && !cpu_gnt;
  end

  // Drive the RAM port from the winning requester, or all zeros when idle.
  always_comb begin
    MEM_EN    = cpu_gnt | vga_gnt;
    MEM_WE    = cpu_gnt & cpu_write;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    if (cpu_gnt) begin
      MEM_ADDR  = CPU_ADDR;
      MEM_WDATA = CPU_WDATA;
    end else if (vga_gnt) begin
      MEM_ADDR  = VGA_ADDR;
    end
  end

  // Pipeline freeze: a pending CPU access that lost, or a read that still
  // needs its data cycle. A granted write completes in place.
  always_comb begin
    CPU_STALL = cpu_pending && (!cpu_gnt || !cpu_write);
    VGA_GNT   = vga_gnt;
  end

  // Route last cycle's RAM read data to the side that issued it.
  always_comb begin
    CPU_RVALID = (owner == OWN_CPU);
    VGA_RVALID = (owner == OWN_VGA);
    CPU_RDATA  = (owner == OWN_CPU) ? MEM_RDATA : '0;
    VGA_RDATA  = (owner == OWN_VGA) ? MEM_RDATA : '0;
  end

  // CPU FSM: a granted read blocks re-issue for the one cycle in which the
  // pipeline is still holding CPU_RD while it picks up the returned data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cpu_state <= C_IDLE;
    end else begin
      case (cpu_state)
        C_IDLE:   if (cpu_gnt && !cpu_write) cpu_state <= C_RDWAIT;
        C_RDWAIT: cpu_state <= C_IDLE;
        default:  cpu_state <= C_IDLE;
      endcase
    end
  end

  // Count consecutive lost cycles so the CPU cannot be starved by scan-out.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cpu_wait <= '0;
    end else if (!cpu_req || cpu_gnt) begin
      cpu_wait <= '0;
    end else if (cpu_pending && (cpu_wait != WAIT_LIMIT)) begin
      cpu_wait <= cpu_wait + 1'b1;
    end
  end

  // Remember who issued a read so the next cycle's data goes to them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner <= OWN_NONE;
    end else if (cpu_gnt && !cpu_write) begin
      owner <= OWN_CPU;
    end else if (vga_gnt) begin
      owner <= OWN_VGA;
    end else begin
      owner <= OWN_NONE;
    end
  end

endmodule

// File: tb/tb_otter_fb_arbiter.sv
// tb_otter_fb_arbiter: vector table driving the arbiter cycle by cycle, a
// synchronous RAM model behind it, and a scoreboard of expected read returns.
module tb_otter_fb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_stall;
  logic        vga_req;
  logic [11:0] vga_addr;
  logic        vga_gnt;
  logic [7:0]  vga_rdata;
  logic        vga_rvalid;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int total = 0;
  int bad   = 0;

  otter_fb_arbiter #(
    .ADDR_W(12),
    .DATA_W(8),
    .MAX_CPU_WAIT(4)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .CPU_RD(cpu_rd),
    .CPU_WR(cpu_wr),
    .CPU_ADDR(cpu_addr),
    .CPU_WDATA(cpu_wdata),
    .CPU_RDATA(cpu_rdata),
    .CPU_RVALID(cpu_rvalid),
    .CPU_STALL(cpu_stall),
    .VGA_REQ(vga_req),
    .VGA_ADDR(vga_addr),
    .VGA_GNT(vga_gnt),
    .VGA_RDATA(vga_rdata),
    .VGA_RVALID(vga_rvalid),
    .MEM_EN(mem_en),
    .MEM_WE(mem_we),
    .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Power-on RAM contents: a fixed pattern per address.
  function automatic logic [7:0] pattern(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
  endfunction

  // Synchronous-read RAM model; contents are loaded on the first edge.
  logic [7:0] ram [0:4095];
  logic       ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 4096; i++) ram[i] <= pattern(12'(i));
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Reference view of memory: pattern plus the writes the bench has issued.
  logic [7:0] ref_wr [int];
  function automatic logic [7:0] ref_read(input logic [11:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return pattern(a);
  endfunction

  typedef struct {
    logic        is_vga;
    logic [7:0]  data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [11:0] caddr;
    logic [7:0]  wdata;
    logic        vreq;
    logic [11:0] vaddr;
    logic        en;
    logic        we;
    logic [11:0] maddr;
    logic        stall;
    logic        vgnt;
    logic        crv;
    logic        vrv;
    logic        wait0;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic rd, input logic wr, input logic [11:0] caddr,
    input logic [7:0] wdata, input logic vreq, input logic [11:0] vaddr,
    input logic en, input logic we, input logic [11:0] maddr, input logic stall,
    input logic vgnt, input logic crv, input logic vrv, input logic wait0);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.caddr = caddr; v.wdata = wdata;
    v.vreq = vreq; v.vaddr = vaddr; v.en = en; v.we = we; v.maddr = maddr;
    v.stall = stall; v.vgnt = vgnt; v.crv = crv; v.vrv = vrv; v.wait0 = wait0;
    return v;
  endfunction

  task automatic check_output(input string name, input int idx,
                              input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s (step %0d): got=0x%0h expected=0x%0h", name, idx, got, want);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst_n     = v.rst;
    cpu_rd    = v.rd;
    cpu_wr    = v.wr;
    cpu_addr  = v.caddr;
    cpu_wdata = v.wdata;
    vga_req   = v.vreq;
    vga_addr  = v.vaddr;
    #2;
  endtask

  // Compare returned read data against the oldest outstanding expectation.
  task automatic check_returns(input int idx);
    sb_t e;
    if (cpu_rvalid) begin
      if (sb_q.size() == 0) begin
        check_output("cpu_unexpected_rvalid", idx, 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        check_output("cpu_ret_owner", idx, 32'(0), 32'(e.is_vga));
        check_output("cpu_rdata", idx, 32'(cpu_rdata), 32'(e.data));
      end
    end else begin
      check_output("cpu_rdata_idle", idx, 32'(cpu_rdata), 32'(0));
    end
    if (vga_rvalid) begin
      if (sb_q.size() == 0) begin
        check_output("vga_unexpected_rvalid", idx, 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        check_output("vga_ret_owner", idx, 32'(1), 32'(e.is_vga));
        check_output("vga_rdata", idx, 32'(vga_rdata), 32'(e.data));
      end
    end else begin
      check_output("vga_rdata_idle", idx, 32'(vga_rdata), 32'(0));
    end
  endtask

  task automatic check_vector(input vec_t v, input int idx);
    sb_t e;
    check_output("mem_en", idx, 32'(mem_en), 32'(v.en));
    check_output("mem_we", idx, 32'(mem_we), 32'(v.we));
    check_output("mem_addr", idx, 32'(mem_addr), 32'(v.maddr));
    check_output("cpu_stall", idx, 32'(cpu_stall), 32'(v.stall));
    check_output("vga_gnt", idx, 32'(vga_gnt), 32'(v.vgnt));
    check_output("cpu_rvalid", idx, 32'(cpu_rvalid), 32'(v.crv));
    check_output("vga_rvalid", idx, 32'(vga_rvalid), 32'(v.vrv));
    if (v.en && v.we) check_output("mem_wdata", idx, 32'(mem_wdata), 32'(v.wdata));
    if (v.wait0) check_output("cpu_wait_zero", idx, 32'(dut.cpu_wait), 32'(0));
    check_returns(idx);
    if (v.en && !v.we) begin
      e.is_vga = v.vgnt;
      e.data   = ref_read(v.maddr);
      sb_q.push_back(e);
    end
    if (v.en && v.we) ref_wr[int'(v.caddr)] = v.wdata;
  endtask

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;

    //            rst rd wr caddr   wdata  vq vaddr    en we maddr  st vg crv vrv w0
    // reset with every request high, then an immediate write on release
    vecs.push_back(mk(0,1,1,12'h010,8'hA5,1,12'h020, 0,0,12'h000,0,0,0,0,0));
    vecs.push_back(mk(0,1,1,12'h010,8'hA5,1,12'h020, 0,0,12'h000,0,0,0,0,0));
    vecs.push_back(mk(1,0,1,12'h010,8'hA5,0,12'h000, 1,1,12'h010,0,0,0,0,0));
    // uncontended read: one stall cycle, no re-issue while data returns
    vecs.push_back(mk(1,1,0,12'h010,8'h00,0,12'h000, 1,0,12'h010,1,0,0,0,0));
    vecs.push_back(mk(1,1,0,12'h010,8'h00,0,12'h000, 0,0,12'h000,0,0,1,0,1));
    vecs.push_back(mk(1,0,0,12'h000,8'h00,0,12'h000, 0,0,12'h000,0,0,0,0,1));
    // starvation: four VGA wins, then the CPU write is forced through
    vecs.push_back(mk(1,0,1,12'h055,8'h3E,1,12'h100, 1,0,12'h100,1,1,0,0,1));
    vecs.push_back(mk(1,0,1,12'h055,8'h3E,1,12'h101, 1,0,12'h101,1,1,0,1,0));
    vecs.push_back(mk(1,0,1,12'h055,8'h3E,1,12'h102, 1,0,12'h102,1,1,0,1,0));
    vecs.push_back(mk(1,0,1,12'h055,8'h3E,1,12'h103, 1,0,12'h103,1,1,0,1,0));
    vecs.push_back(mk(1,0,1,12'h055,8'h3E,1,12'h104, 1,1,12'h055,0,0,0,1,0));
    vecs.push_back(mk(1,0,0,12'h000,8'h00,0,12'h000, 0,0,12'h000,0,0,0,0,1));
    // interleave: VGA first, then CPU read, VGA reuses the RDWAIT slot
    vecs.push_back(mk(1,1,0,12'h055,8'h00,1,12'h200, 1,0,12'h200,1,1,0,0,1));
    vecs.push_back(mk(1,1,0,12'h055,8'h00,0,12'h000, 1,0,12'h055,1,0,0,1,0));
    vecs.push_back(mk(1,1,0,12'h055,8'h00,1,12'h201, 1,0,12'h201,0,1,1,0,0));
    vecs.push_back(mk(1,0,0,12'h000,8'h00,0,12'h000, 0,0,12'h000,0,0,0,1,1));
    // read and write together behave as a single write
    vecs.push_back(mk(1,1,1,12'h077,8'hC3,0,12'h000, 1,1,12'h077,0,0,0,0,1));
    vecs.push_back(mk(1,0,0,12'h000,8'h00,0,12'h000, 0,0,12'h000,0,0,0,0,1));
    vecs.push_back(mk(1,1,0,12'h077,8'h00,0,12'h000, 1,0,12'h077,1,0,0,0,1));
    vecs.push_back(mk(1,1,0,12'h077,8'h00,0,12'h000, 0,0,12'h000,0,0,1,0,1));
    vecs.push_back(mk(1,0,0,12'h000,8'h00,0,12'h000, 0,0,12'h000,0,0,0,0,1));
    // starved read: five stall cycles, then VGA takes the RDWAIT slot
    vecs.push_back(mk(1,1,0,12'h010,8'h00,1,12'h300, 1,0,12'h300,1,1,0,0,1));
    vecs.push_back(mk(1,1,0,12'h010,8'h00,1,12'h301, 1,0,12'h301,1,1,0,1,0));
    vecs.push_back(mk(1,1,0,12'h010,8'h00,1,12'h302, 1,0,12'h302,1,1,0,1,0));
    vecs.push_back(mk(1,1,0,12'h010,8'h00,1,12'h303, 1,0,12'h303,1,1,0,1,0));
    vecs.push_back(mk(1,1,0,12'h010,8'h00,1,12'h304, 1,0,12'h010,1,0,0,1,0));
    vecs.push_back(mk(1,1,0,12'h010,8'h00,1,12'h304, 1,0,12'h304,0,1,1,0,1));
    vecs.push_back(mk(1,0,0,12'h000,8'h00,0,12'h000, 0,0,12'h000,0,0,0,1,1));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_vector(vecs[i], i);
    end

    // reset asserted during the RDWAIT cycle drops the in-flight read
    @(posedge clk); #1;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 12'h055; vga_req = 1'b0;
    #2;
    check_output("midrd_issue_en", 100, 32'(mem_en), 32'(1));
    check_output("midrd_issue_stall", 100, 32'(cpu_stall), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_output("midrd_rst_rvalid", 101, 32'(cpu_rvalid), 32'(0));
    check_output("midrd_rst_rdata", 101, 32'(cpu_rdata), 32'(0));
    check_output("midrd_rst_en", 101, 32'(mem_en), 32'(0));
    check_output("midrd_rst_stall", 101, 32'(cpu_stall), 32'(0));
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    #1;
    check_output("midrd_hold_rvalid", 102, 32'(cpu_rvalid), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      check_output("midrd_post_cpu_rvalid", 103 + k, 32'(cpu_rvalid), 32'(0));
      check_output("midrd_post_vga_rvalid", 103 + k, 32'(vga_rvalid), 32'(0));
      @(posedge clk); #1;
    end
    cpu_wr = 1'b1; cpu_addr = 12'h0AA; cpu_wdata = 8'h5A; vga_req = 1'b0;
    #2;
    check_output("midrd_idle_en", 106, 32'(mem_en), 32'(1));
    check_output("midrd_idle_we", 106, 32'(mem_we), 32'(1));
    check_output("midrd_idle_addr", 106, 32'(mem_addr), 32'(12'h0AA));
    check_output("midrd_idle_stall", 106, 32'(cpu_stall), 32'(0));
    @(posedge clk); #1;
    cpu_wr = 1'b0;
    #2;
    check_output("scoreboard_drained", 107, 32'(sb_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/otter_fb_arbiter.md
# otter_fb_arbiter

Single-port framebuffer memory arbiter between the OTTER pipeline MEM stage (load/store to the framebuffer window) and the VGA scan-out fetcher. It issues at most one access per cycle to a synchronous-read RAM, returns read data to the winning requester, and freezes the pipeline through `CPU_STALL` whenever a CPU access cannot complete this cycle. VGA has priority. A starvation counter guarantees the CPU a slot within a bounded number of cycles.

## Interface
- `ADDR_W`, 12: framebuffer word-address width.
- `DATA_W`, 8: framebuffer word width (one pixel).
- `MAX_CPU_WAIT`, 4: consecutive lost cycles after which the CPU wins over VGA; legal range ≥1.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `CPU_RD` in 1: MEM-stage load request (decoder `MEMREAD2` qualified by address decode). Held until `CPU_STALL` is low.
- `CPU_WR` in 1: MEM-stage store request. Held until `CPU_STALL` is low.
- `CPU_ADDR` in ADDR_W: CPU word address.
- `CPU_WDATA` in DATA_W: store data.
- `CPU_RDATA` out DATA_W: load data, valid when `CPU_RVALID`=1.
- `CPU_RVALID` out 1: load data valid this cycle.
- `CPU_STALL` out 1: freeze IF..MEM this cycle.
- `VGA_REQ` in 1: fetch request. Level signal; `VGA_ADDR` is held stable until granted.
- `VGA_ADDR` in ADDR_W: fetch address.
- `VGA_GNT` out 1: VGA request issued this cycle.
- `VGA_RDATA` out DATA_W: fetched pixel, valid with `VGA_RVALID`.
- `VGA_RVALID` out 1: fetch data valid (cycle after `VGA_GNT`).
- `MEM_EN` out 1: RAM access this cycle.
- `MEM_WE` out 1: RAM write this cycle.
- `MEM_ADDR` out ADDR_W: RAM address.
- `MEM_WDATA` out DATA_W: RAM write data.
- `MEM_RDATA` in DATA_W: RAM read data, one cycle after an `MEM_EN`=1, `MEM_WE`=0 access.

## Operation
- **CPU FSM.**
  - `C_IDLE`: a CPU request is eligible for issue.
  - `C_RDWAIT`: a read was issued last cycle; the CPU is not eligible.
  - `C_IDLE` → `C_RDWAIT` when a CPU read is granted. `C_RDWAIT` → `C_IDLE` unconditionally after one cycle.
- **Request priority.** `CPU_RD`=`CPU_WR`=1 is treated as a write.
- **Grant rule**, evaluated each cycle from the current inputs and state:
  - CPU eligible and (`VGA_REQ`=0 or `cpu_wait`==MAX_CPU_WAIT) → CPU granted.
  - Otherwise, `VGA_REQ`=1 → VGA granted.
  - Otherwise → no access; `MEM_EN`=0.
- **Memory drive.**
  - `MEM_ADDR`/`MEM_WDATA`/`MEM_WE` are driven from the granted requester.
  - `MEM_WE` = CPU granted and write.
  - `MEM_EN` = any grant.
  - When idle, `MEM_ADDR` and `MEM_WDATA` are 0.
- **`cpu_wait` counter** (width clog2(MAX_CPU_WAIT+1)):
  - Increments when a CPU request is pending in `C_IDLE` and not granted.
  - Saturates at MAX_CPU_WAIT.
  - Clears when the CPU is granted or has no request.
- **`CPU_STALL`** =
  - (`C_IDLE` and request pending and not granted), or
  - (`C_IDLE` and a read is granted).
  - It is 0 in `C_RDWAIT`, 0 for a granted write, and 0 with no request.
- **Read return.**
  - A registered owner tag (`NONE`/`CPU`/`VGA`) records the issuing requester.
  - Next cycle, `MEM_RDATA` is routed to the tagged port and its `RVALID` is pulsed.
  - The untagged port's RDATA is 0.
- **Re-issue guard.** In `C_RDWAIT`, `CPU_RD` is still high because the pipeline is just releasing. It must not be re-issued; VGA may use that slot.
- **Reset.**
  - `RST_N`=0 asynchronously forces `C_IDLE`, `cpu_wait`=0, and owner tag `NONE`.
  - All outputs are 0 while `RST_N`=0, including `CPU_STALL`, `MEM_EN`, both `RVALID`s, and `VGA_GNT`.
  - An in-flight read is dropped; no `RVALID` follows release.

## Timing
- CPU write, uncontended: granted in cycle N, `CPU_STALL`=0 in N, RAM written at the end of N. Zero stall.
- CPU read, uncontended: granted in N with `CPU_STALL`=1. In N+1, `CPU_RVALID`=1, `CPU_RDATA`=`MEM_RDATA`, `CPU_STALL`=0. One stall cycle.
- VGA: `VGA_GNT` in N, `VGA_RVALID` in N+1.
- Worst-case CPU latency under continuous `VGA_REQ`: MAX_CPU_WAIT lost cycles, then granted. Stall is MAX_CPU_WAIT cycles for a write and MAX_CPU_WAIT+1 for a read.
- Back-to-back reads: CPU read in N, VGA read in N+1 (`C_RDWAIT`); data returns in N+1 and N+2 respectively. Throughput is one access per cycle.
- All outputs are combinational from the registered state plus the current inputs. No input-to-output path to `MEM_RDATA` other than the RDATA mux.

## Test plan
- **Reset.** Hold `RST_N`=0 with all requests high → all outputs 0. Release, with `CPU_WR`=1, `CPU_ADDR`=0x010, `CPU_WDATA`=0xA5 → `MEM_EN`=`MEM_WE`=1, `MEM_ADDR`=0x010, `CPU_STALL`=0 the same cycle.
- **Uncontended read.** Read 0x010 after the write above, RAM model 1-cycle → `CPU_STALL` high exactly 1 cycle, then `CPU_RVALID`=1, `CPU_RDATA`=0xA5. No second `MEM_EN` for the CPU in the `C_RDWAIT` cycle.
- **Starvation bound.** `VGA_REQ` held high with incrementing `VGA_ADDR`, `CPU_WR`=1, MAX_CPU_WAIT=4 → four `VGA_GNT`s, then CPU granted in the fifth cycle. `CPU_STALL` high for exactly 4 cycles; `cpu_wait` returns to 0.
- **Interleave.** CPU read and VGA request in the same cycle with `cpu_wait`=0 → VGA granted first, CPU next cycle. `VGA_RVALID` then `CPU_RVALID` on consecutive cycles with the correct data per owner.
- **Simultaneous `CPU_RD`=`CPU_WR`=1** → single write issued, no `CPU_RVALID`.
- **Reset mid-read.** Assert `RST_N`=0 in the `C_RDWAIT` cycle → `CPU_RVALID` never pulses after release; the FSM is in `C_IDLE`.
